// File: rtl/tx_shell_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_shell_gate_pkg
// Brief   : CCI-P Tx channel types and default gate depths shared with the mux.
// Rev     : 1.0  initial release
// ============================================================================
package tx_shell_gate_pkg;

    localparam int TX_GATE_N_ENTRIES     = 64;
    localparam int TX_GATE_ALMFULL_SLACK = 8;
    localparam int TX_GATE_CNT_W         = 16;

    localparam int CCIP_CLDATA_W   = 512;
    localparam int CCIP_MMIODATA_W = 64;

    localparam logic [3:0] CCIP_REQ_RDLINE_I = 4'h0;
    localparam logic [3:0] CCIP_REQ_RDLINE_S = 4'h1;
    localparam logic [3:0] CCIP_REQ_WRLINE_I = 4'h2;
    localparam logic [3:0] CCIP_REQ_WRLINE_M = 4'h3;

    typedef struct packed {
        logic [3:0]  req_type;
        logic [1:0]  cl_len;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [3:0]  req_type;
        logic [1:0]  cl_len;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr       hdr;
        logic [CCIP_CLDATA_W-1:0] data;
        logic                     valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr        hdr;
        logic                       mmioRdValid;
        logic [CCIP_MMIODATA_W-1:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage
`default_nettype wire

// File: rtl/tx_shell_gate_if.sv
`default_nettype none
// ============================================================================
// Module  : tx_shell_gate_if
// Brief   : Merged CCI-P Tx bundle plus the per-channel almost-full back-pressure.
// Rev     : 1.0  initial release
// ============================================================================
interface tx_shell_gate_if
    import tx_shell_gate_pkg::*;
();
    t_if_ccip_Tx tx;
    logic        c0_alm_full;
    logic        c1_alm_full;

    // Master sends requests and obeys almost-full; slave receives and throttles.
    modport master (output tx, input  c0_alm_full, input  c1_alm_full);
    modport slave  (input  tx, output c0_alm_full, output c1_alm_full);
endinterface
`default_nettype wire

// File: rtl/tx_shell_gate_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tx_shell_gate_fifo
// Brief   : Flop-based sync FIFO with registered occupancy-based almost-full.
// Rev     : 1.0  initial release
// ============================================================================
module tx_shell_gate_fifo
    import tx_shell_gate_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int N_ENTRIES     = TX_GATE_N_ENTRIES,
    parameter int ALMFULL_SLACK = TX_GATE_ALMFULL_SLACK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] first,
    output logic             empty,
    output logic             full,
    output logic             alm_full
);
    localparam int PTR_W  = $clog2(N_ENTRIES);
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(N_ENTRIES);
    localparam logic [CNT_FW-1:0] AF_CNT   = CNT_FW'(N_ENTRIES - ALMFULL_SLACK);

    logic [WIDTH-1:0]  mem [N_ENTRIES];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] count;
    logic [CNT_FW-1:0] count_next;
    logic              do_enq;
    logic              do_deq;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign do_deq = deq && !empty;
    assign do_enq = enq && (!full || do_deq);

    always_comb begin
        count_next = count;
        case ({do_enq, do_deq})
            2'b10:   count_next = count + CNT_FW'(1);
            2'b01:   count_next = count - CNT_FW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            alm_full <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            alm_full <= (count_next >= AF_CNT);
        end
    end

    // Storage carries no reset; only valid slots are ever read out.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

    assign first = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
endmodule
`default_nettype wire

// File: rtl/tx_shell_gate.sv
`default_nettype none
// ============================================================================
// Module  : tx_shell_gate
// Brief   : Elastic c0/c1 buffering between Tx mux and shell, gated by shell almFull.
// Rev     : 1.0  initial release
// ============================================================================
module tx_shell_gate
    import tx_shell_gate_pkg::*;
#(
    parameter int N_ENTRIES     = TX_GATE_N_ENTRIES,
    parameter int ALMFULL_SLACK = TX_GATE_ALMFULL_SLACK,
    parameter int CNT_W         = TX_GATE_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    tx_shell_gate_if.slave     in_if,
    tx_shell_gate_if.master    out_if,
    output logic               overflow,
    output logic [CNT_W-1:0]   c0_drop_cnt,
    output logic [CNT_W-1:0]   c1_drop_cnt
);
    localparam int C0_W = $bits(t_ccip_c0_ReqMemHdr);
    localparam int C1_W = $bits(t_ccip_c1_ReqMemHdr) + CCIP_CLDATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            almfull_c0_q;
    logic            almfull_c1_q;
    logic            c0_empty, c0_full, c0_up_almfull, c0_deq, c0_drop;
    logic            c1_empty, c1_full, c1_up_almfull, c1_deq, c1_drop;
    logic [C0_W-1:0] c0_first;
    logic [C1_W-1:0] c1_first;
    t_if_ccip_Tx     tx_next;
    t_if_ccip_Tx     tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almfull_c0_q <= 1'b0;
            almfull_c1_q <= 1'b0;
        end else begin
            almfull_c0_q <= out_if.c0_alm_full;
            almfull_c1_q <= out_if.c1_alm_full;
        end
    end

    // Channels are gated independently so a stalled c0 never holds up c1.
    assign c0_deq  = !c0_empty && !almfull_c0_q;
    assign c1_deq  = !c1_empty && !almfull_c1_q;
    assign c0_drop = in_if.tx.c0.valid && c0_full && !c0_deq;
    assign c1_drop = in_if.tx.c1.valid && c1_full && !c1_deq;

    tx_shell_gate_fifo #(
        .WIDTH         (C0_W),
        .N_ENTRIES     (N_ENTRIES),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_c0_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (in_if.tx.c0.valid),
        .enq_data (in_if.tx.c0.hdr),
        .deq      (c0_deq),
        .first    (c0_first),
        .empty    (c0_empty),
        .full     (c0_full),
        .alm_full (c0_up_almfull)
    );

    tx_shell_gate_fifo #(
        .WIDTH         (C1_W),
        .N_ENTRIES     (N_ENTRIES),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_c1_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (in_if.tx.c1.valid),
        .enq_data ({in_if.tx.c1.hdr, in_if.tx.c1.data}),
        .deq      (c1_deq),
        .first    (c1_first),
        .empty    (c1_empty),
        .full     (c1_full),
        .alm_full (c1_up_almfull)
    );

    always_comb begin
        tx_next = '0;
        if (c0_deq) begin
            tx_next.c0.hdr   = c0_first;
            tx_next.c0.valid = 1'b1;
        end
        if (c1_deq) begin
            {tx_next.c1.hdr, tx_next.c1.data} = c1_first;
            tx_next.c1.valid = 1'b1;
        end
        // MMIO read responses bypass the gate entirely.
        tx_next.c2 = in_if.tx.c2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_q <= '0;
        else       tx_q <= tx_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            c0_drop_cnt <= '0;
            c1_drop_cnt <= '0;
        end else begin
            if (c0_drop || c1_drop) overflow <= 1'b1;
            if (c0_drop && (c0_drop_cnt != CNT_MAX)) c0_drop_cnt <= c0_drop_cnt + CNT_W'(1);
            if (c1_drop && (c1_drop_cnt != CNT_MAX)) c1_drop_cnt <= c1_drop_cnt + CNT_W'(1);
        end
    end

    assign out_if.tx          = tx_q;
    assign in_if.c0_alm_full  = c0_up_almfull;
    assign in_if.c1_alm_full  = c1_up_almfull;
endmodule
`default_nettype wire

// File: tb/tb_tx_shell_gate.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_shell_gate
// Brief   : Queue-model bench for tx_shell_gate: directed scenarios plus random traffic.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tx_shell_gate;
    import tx_shell_gate_pkg::*;

    localparam int N     = TX_GATE_N_ENTRIES;
    localparam int SLACK = TX_GATE_ALMFULL_SLACK;
    localparam int CNT_W = TX_GATE_CNT_W;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             overflow;
    logic [CNT_W-1:0] c0_drop_cnt;
    logic [CNT_W-1:0] c1_drop_cnt;

    tx_shell_gate_if in_if ();
    tx_shell_gate_if out_if ();

    tx_shell_gate dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (in_if),
        .out_if      (out_if),
        .overflow    (overflow),
        .c0_drop_cnt (c0_drop_cnt),
        .c1_drop_cnt (c1_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input bit ok, input string act, input string req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%s required=%s", name, act, req);
        end
    endtask

    // ---------------- reference model: one queue per channel ----------------
    t_if_ccip_c0_Tx q0[$];
    t_if_ccip_c1_Tx q1[$];
    t_if_ccip_Tx    exp_tx  = '0;
    t_if_ccip_Tx    m_nx;
    bit             exp_up0 = 0, exp_up1 = 0, exp_ovf = 0;
    int             exp_d0  = 0, exp_d1  = 0;
    bit             m_af0   = 0, m_af1   = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete(); q1.delete();
            exp_tx = '0; exp_up0 = 0; exp_up1 = 0; exp_ovf = 0;
            exp_d0 = 0; exp_d1 = 0; m_af0 = 0; m_af1 = 0;
        end else begin
            m_nx = '0;
            if (q0.size() > 0 && !m_af0) m_nx.c0 = q0.pop_front();
            if (q1.size() > 0 && !m_af1) m_nx.c1 = q1.pop_front();
            if (in_if.tx.c0.valid) begin
                if (q0.size() < N) q0.push_back(in_if.tx.c0);
                else begin exp_ovf = 1; if (exp_d0 < MAXC) exp_d0++; end
            end
            if (in_if.tx.c1.valid) begin
                if (q1.size() < N) q1.push_back(in_if.tx.c1);
                else begin exp_ovf = 1; if (exp_d1 < MAXC) exp_d1++; end
            end
            m_nx.c2 = in_if.tx.c2;
            exp_tx  = m_nx;
            exp_up0 = (q0.size() >= N - SLACK);
            exp_up1 = (q1.size() >= N - SLACK);
            m_af0   = out_if.c0_alm_full;
            m_af1   = out_if.c1_alm_full;
        end
    end

    // ---------------- compare process + output monitor ----------------
    int                 n_c0_out = 0;
    t_ccip_c1_ReqMemHdr seen_c1[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_c0", out_if.tx.c0 === exp_tx.c0,
                  $sformatf("%h", out_if.tx.c0), $sformatf("%h", exp_tx.c0));
            check("cmp_c1", out_if.tx.c1 === exp_tx.c1,
                  $sformatf("%h", out_if.tx.c1), $sformatf("%h", exp_tx.c1));
            check("cmp_c2", out_if.tx.c2 === exp_tx.c2,
                  $sformatf("%h", out_if.tx.c2), $sformatf("%h", exp_tx.c2));
            check("cmp_up", {in_if.c0_alm_full, in_if.c1_alm_full} === {exp_up0, exp_up1},
                  $sformatf("%b%b", in_if.c0_alm_full, in_if.c1_alm_full),
                  $sformatf("%b%b", exp_up0, exp_up1));
            check("cmp_ovf", overflow === exp_ovf,
                  $sformatf("%b", overflow), $sformatf("%b", exp_ovf));
            check("cmp_drop", {c0_drop_cnt, c1_drop_cnt} === {CNT_W'(exp_d0), CNT_W'(exp_d1)},
                  $sformatf("%0d/%0d", c0_drop_cnt, c1_drop_cnt),
                  $sformatf("%0d/%0d", exp_d0, exp_d1));
        end
        if (out_if.tx.c0.valid === 1'b1) n_c0_out++;
        if (out_if.tx.c1.valid === 1'b1) seen_c1.push_back(out_if.tx.c1.hdr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CCIP_CLDATA_W-1:0] rand_cl();
        logic [CCIP_CLDATA_W-1:0] d;
        for (int i = 0; i < CCIP_CLDATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic t_ccip_c0_ReqMemHdr rand_c0hdr();
        return {$urandom, $urandom};
    endfunction

    function automatic t_ccip_c1_ReqMemHdr rand_c1hdr();
        return {$urandom, $urandom};
    endfunction

    task automatic push_c1();
        in_if.tx.c1.valid = 1'b1;
        in_if.tx.c1.hdr   = rand_c1hdr();
        in_if.tx.c1.data  = rand_cl();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios then random traffic ----------------
    t_ccip_c0_ReqMemHdr h0;
    t_ccip_c0_ReqMemHdr h0s[10];
    t_ccip_c1_ReqMemHdr g1s[3];
    t_if_ccip_c2_Tx     c2s;
    int                 base, k;
    int                 seg_p[5]  = '{30, 70, 95, 95, 50};
    int                 seg_af[5] = '{20, 50, 85, 30, 0};

    initial begin
        in_if.tx = '0;
        out_if.c0_alm_full = 1'b0;
        out_if.c1_alm_full = 1'b0;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_out", out_if.tx === '0, $sformatf("%h", out_if.tx.c2), "0");
        check("rst_up", {in_if.c0_alm_full, in_if.c1_alm_full} === 2'b00,
              $sformatf("%b%b", in_if.c0_alm_full, in_if.c1_alm_full), "00");
        check("rst_ovf", overflow === 1'b0, $sformatf("%b", overflow), "0");
        check("rst_cnt", {c0_drop_cnt, c1_drop_cnt} === '0,
              $sformatf("%0d/%0d", c0_drop_cnt, c1_drop_cnt), "0/0");

        // Single RdLine: valid two edges after being presented.
        h0 = rand_c0hdr();
        h0.req_type = CCIP_REQ_RDLINE_I;
        in_if.tx.c0.hdr = h0; in_if.tx.c0.valid = 1'b1;
        tick(); in_if.tx = '0;
        check("lat_e1", out_if.tx.c0.valid === 1'b0, $sformatf("%b", out_if.tx.c0.valid), "0");
        tick();
        check("lat_e2", out_if.tx.c0.valid === 1'b1 && out_if.tx.c0.hdr === h0,
              $sformatf("%b/%h", out_if.tx.c0.valid, out_if.tx.c0.hdr), $sformatf("1/%h", h0));
        tick();
        check("lat_e3", out_if.tx.c0.valid === 1'b0, $sformatf("%b", out_if.tx.c0.valid), "0");

        // c0 stalled: c1 still flows; release drains 10 back to back.
        out_if.c0_alm_full = 1'b1;
        tick(); tick();
        base = n_c0_out; seen_c1.delete();
        for (int i = 0; i < 10; i++) begin
            in_if.tx = '0;
            h0s[i] = rand_c0hdr();
            in_if.tx.c0.valid = 1'b1; in_if.tx.c0.hdr = h0s[i];
            if (i < 3) begin push_c1(); g1s[i] = in_if.tx.c1.hdr; end
            tick();
        end
        in_if.tx = '0;
        tick(); tick();
        check("stall_c0", n_c0_out == base, $sformatf("%0d", n_c0_out - base), "0");
        check("stall_c1n", seen_c1.size() == 3, $sformatf("%0d", seen_c1.size()), "3");
        for (int i = 0; i < 3; i++)
            check("stall_c1ord", (i < seen_c1.size()) ? (seen_c1[i] === g1s[i]) : 1'b0,
                  $sformatf("%0d", seen_c1.size()), $sformatf("%h", g1s[i]));
        out_if.c0_alm_full = 1'b0;
        k = 0;
        while (out_if.tx.c0.valid !== 1'b1 && k < 5) begin tick(); k++; end
        for (int i = 0; i < 10; i++) begin
            check("rel_order", out_if.tx.c0.valid === 1'b1 && out_if.tx.c0.hdr === h0s[i],
                  $sformatf("%b/%h", out_if.tx.c0.valid, out_if.tx.c0.hdr), $sformatf("1/%h", h0s[i]));
            tick();
        end
        check("rel_end", out_if.tx.c0.valid === 1'b0, $sformatf("%b", out_if.tx.c0.valid), "0");

        // Upstream almost-full threshold on c1.
        out_if.c1_alm_full = 1'b1;
        tick(); tick();
        for (int i = 0; i < 56; i++) begin
            in_if.tx = '0; push_c1();
            tick();
            if (i == 54) check("af_55", in_if.c1_alm_full === 1'b0, $sformatf("%b", in_if.c1_alm_full), "0");
            if (i == 55) check("af_56", in_if.c1_alm_full === 1'b1, $sformatf("%b", in_if.c1_alm_full), "1");
        end
        in_if.tx = '0;
        out_if.c1_alm_full = 1'b0;
        tick();
        out_if.c1_alm_full = 1'b1;
        check("af_hold", in_if.c1_alm_full === 1'b1, $sformatf("%b", in_if.c1_alm_full), "1");
        tick();
        check("af_drain", in_if.c1_alm_full === 1'b0 && out_if.tx.c1.valid === 1'b1,
              $sformatf("%b/%b", in_if.c1_alm_full, out_if.tx.c1.valid), "0/1");
        tick();
        check("af_stay", in_if.c1_alm_full === 1'b0 && out_if.tx.c1.valid === 1'b0,
              $sformatf("%b/%b", in_if.c1_alm_full, out_if.tx.c1.valid), "0/0");
        out_if.c1_alm_full = 1'b0;
        repeat (60) tick();

        // Overflow: 65 pushes into a stalled 64-deep c0.
        out_if.c0_alm_full = 1'b1;
        tick(); tick();
        for (int i = 0; i < 65; i++) begin
            in_if.tx = '0;
            in_if.tx.c0.valid = 1'b1; in_if.tx.c0.hdr = rand_c0hdr();
            tick();
        end
        in_if.tx = '0;
        check("ovf_drop", c0_drop_cnt === CNT_W'(1) && overflow === 1'b1,
              $sformatf("%0d/%b", c0_drop_cnt, overflow), "1/1");
        out_if.c0_alm_full = 1'b0;
        base = n_c0_out;
        repeat (70) tick();
        check("ovf_out64", n_c0_out - base == 64, $sformatf("%0d", n_c0_out - base), "64");
        check("ovf_sticky", overflow === 1'b1, $sformatf("%b", overflow), "1");

        // c2 passes through while both request channels are stalled.
        out_if.c0_alm_full = 1'b1; out_if.c1_alm_full = 1'b1;
        tick(); tick();
        c2s = '0; c2s.hdr.tid = 9'h1A2; c2s.mmioRdValid = 1'b1; c2s.data = {$urandom, $urandom};
        in_if.tx.c2 = c2s;
        tick(); in_if.tx = '0;
        check("c2_pass", out_if.tx.c2 === c2s, $sformatf("%h", out_if.tx.c2), $sformatf("%h", c2s));
        tick();
        check("c2_gone", out_if.tx.c2.mmioRdValid === 1'b0, $sformatf("%b", out_if.tx.c2.mmioRdValid), "0");

        // Asynchronous reset in the middle of a c1 drain.
        out_if.c0_alm_full = 1'b0;
        for (int i = 0; i < 20; i++) begin in_if.tx = '0; push_c1(); tick(); end
        in_if.tx = '0;
        out_if.c1_alm_full = 1'b0;
        tick(); tick(); tick();
        check("drain_on", out_if.tx.c1.valid === 1'b1, $sformatf("%b", out_if.tx.c1.valid), "1");
        #1 reset = 1'b1;
        #1;
        check("rst_async", out_if.tx === '0, $sformatf("%b", out_if.tx.c1.valid), "0");
        tick(); tick();
        reset = 1'b0;
        check("rst_clr", overflow === 1'b0 && c0_drop_cnt === '0 && c1_drop_cnt === '0,
              $sformatf("%b/%0d/%0d", overflow, c0_drop_cnt, c1_drop_cnt), "0/0/0");
        repeat (3) begin
            tick();
            check("rst_empty", out_if.tx.c1.valid === 1'b0, $sformatf("%b", out_if.tx.c1.valid), "0");
        end

        // Random traffic with varying load and shell back-pressure.
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 600; c++) begin
                in_if.tx = '0;
                if ($urandom_range(99, 0) < seg_p[s]) begin
                    in_if.tx.c0.valid = 1'b1; in_if.tx.c0.hdr = rand_c0hdr();
                end
                if ($urandom_range(99, 0) < seg_p[s]) push_c1();
                if ($urandom_range(99, 0) < 20) begin
                    in_if.tx.c2.mmioRdValid = 1'b1;
                    in_if.tx.c2.hdr.tid     = 9'($urandom);
                    in_if.tx.c2.data        = {$urandom, $urandom};
                end
                out_if.c0_alm_full = ($urandom_range(99, 0) < seg_af[s]);
                out_if.c1_alm_full = ($urandom_range(99, 0) < seg_af[s]);
                if (s == 3 && c == 300) begin
                    #2 reset = 1'b1;
                    #10 reset = 1'b0;
                end
                tick();
            end
        end
        in_if.tx = '0;
        out_if.c0_alm_full = 1'b0; out_if.c1_alm_full = 1'b0;
        repeat (80) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
